// File: rtl/schmidl_cox_peak_detector_if.sv
// Valid/ready stream bundle used for both the metric input and the result output
// of the Schmidl-Cox peak detector.
interface schmidl_cox_peak_detector_if #(
  parameter int unsigned Width = 32
) ();
  logic [Width-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, tlast, tvalid, input tready);
  modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/schmidl_cox_peak_detector.sv
// Finds the largest timing metric in an FFT_SIZE/2 window opened by a threshold crossing.
// Optional macro SC_PEAK_HOLDOFF_EN adds an FFT_SIZE-sample holdoff after each detection.
module schmidl_cox_peak_detector #(
  parameter int unsigned FFT_SIZE = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear,
  input  logic [31:0]                        threshold,
  schmidl_cox_peak_detector_if.slave         s_axis,
  schmidl_cox_peak_detector_if.master        m_axis
);

  localparam logic [31:0] HalfFftSize = 32'(FFT_SIZE / 2);
  localparam logic [1:0]  StIdle      = 2'd0;
  localparam logic [1:0]  StSearch    = 2'd1;
`ifdef SC_PEAK_HOLDOFF_EN
  localparam logic [1:0]  StHoldoff   = 2'd2;
  localparam logic [31:0] HoldoffLast = 32'(FFT_SIZE) - 32'd1;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] win_cnt_q, win_cnt_d;
  logic [31:0] peak_val_q, peak_val_d;
  logic [31:0] peak_idx_q, peak_idx_d;
  logic [63:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
`ifdef SC_PEAK_HOLDOFF_EN
  logic [31:0] hold_cnt_q, hold_cnt_d;
`endif

  logic in_ready, in_fire, out_fire, above_thr, new_peak;
  logic unused_tlast;

  assign unused_tlast = s_axis.tlast;

  assign in_ready  = !out_valid_q || m_axis.tready;
  assign in_fire   = s_axis.tvalid && in_ready;
  assign out_fire  = out_valid_q && m_axis.tready;
  assign above_thr = s_axis.tdata > threshold;
  assign new_peak  = s_axis.tdata > peak_val_q;

  assign s_axis.tready = in_ready;
  assign m_axis.tdata  = out_data_q;
  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tlast  = out_valid_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_cnt_d   = win_cnt_q;
    peak_val_d  = peak_val_q;
    peak_idx_d  = peak_idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef SC_PEAK_HOLDOFF_EN
    hold_cnt_d  = hold_cnt_q;
`endif

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      cnt_d = cnt_q + 32'd1;
      case (state_q)
        StIdle: begin
          if (above_thr) begin
            peak_val_d = s_axis.tdata;
            peak_idx_d = cnt_q;
            win_cnt_d  = 32'd1;
            state_d    = StSearch;
          end
        end
        StSearch: begin
          win_cnt_d = win_cnt_q + 32'd1;
          // Strict compare keeps the earliest of equal peaks.
          if (new_peak) begin
            peak_val_d = s_axis.tdata;
            peak_idx_d = cnt_q;
          end
          if (win_cnt_d == HalfFftSize) begin
            out_data_d  = {peak_idx_d, peak_val_d};
            out_valid_d = 1'b1;
`ifdef SC_PEAK_HOLDOFF_EN
            hold_cnt_d  = 32'd0;
            state_d     = StHoldoff;
`else
            state_d     = StIdle;
`endif
          end
        end
`ifdef SC_PEAK_HOLDOFF_EN
        StHoldoff: begin
          if (hold_cnt_q == HoldoffLast) begin
            hold_cnt_d = 32'd0;
            state_d    = StIdle;
          end else begin
            hold_cnt_d = hold_cnt_q + 32'd1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q     <= StIdle;
      cnt_q       <= 32'd0;
      win_cnt_q   <= 32'd0;
      peak_val_q  <= 32'd0;
      peak_idx_q  <= 32'd0;
      out_data_q  <= 64'd0;
      out_valid_q <= 1'b0;
`ifdef SC_PEAK_HOLDOFF_EN
      hold_cnt_q  <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_cnt_q   <= win_cnt_d;
      peak_val_q  <= peak_val_d;
      peak_idx_q  <= peak_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef SC_PEAK_HOLDOFF_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_schmidl_cox_peak_detector.sv
// Randomized and directed bench for schmidl_cox_peak_detector (FFT_SIZE = 16) against a
// window-scanning reference model over the accepted sample stream.
module tb_schmidl_cox_peak_detector;

  localparam int unsigned FftSize = 16;
  localparam int unsigned Half    = FftSize / 2;
`ifdef SC_PEAK_HOLDOFF_EN
  localparam int unsigned Holdoff = FftSize;
`else
  localparam int unsigned Holdoff = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [31:0] threshold;

  always #5 clk = ~clk;

  schmidl_cox_peak_detector_if #(.Width(32)) in_if ();
  schmidl_cox_peak_detector_if #(.Width(64)) out_if ();

  schmidl_cox_peak_detector #(.FFT_SIZE(FftSize)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .threshold (threshold),
    .s_axis    (in_if),
    .m_axis    (out_if)
  );

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  logic [31:0] seg_data[$];
  int unsigned seg_cyc[$];
  logic [63:0] got_data[$];
  int unsigned got_vis[$];

  bit          chk_ready_hi = 1'b0;
  bit          stall_active = 1'b0;
  int          stall_left   = 0;
  bit          bp_arm       = 1'b0;
  bit          rnd_ready    = 1'b0;
  bit          rnd_gap      = 1'b0;
  logic [63:0] bp_expect    = 64'h0000000C_000001F4;
  int unsigned cur_vis      = 0;
  bit          prev_v       = 1'b0;
  bit          prev_pop     = 1'b0;

  logic [31:0] s2 [8] = '{32'd200, 32'd300, 32'd500, 32'd400, 32'd350, 32'd300, 32'd280, 32'd250};
  logic [31:0] s3 [8] = '{32'd200, 32'd500, 32'd300, 32'd300, 32'd500, 32'd200, 32'd200, 32'd200};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: records accepted samples and delivered results, away from the active edge.
  always @(negedge clk) begin
    if (!reset && !clear) begin
      if (in_if.tvalid && in_if.tready) begin
        seg_data.push_back(in_if.tdata);
        seg_cyc.push_back(cyc);
      end
      if (chk_ready_hi) check_eq("i_tready_free", 64'(in_if.tready), 64'd1);
      if (stall_active) begin
        check_eq("bp_i_tready", 64'(in_if.tready), 64'd0);
        check_eq("bp_o_tvalid", 64'(out_if.tvalid), 64'd1);
        check_eq("bp_o_tdata", out_if.tdata, bp_expect);
      end
      if (out_if.tvalid && (!prev_v || prev_pop)) cur_vis = cyc;
      if (out_if.tvalid && out_if.tready) begin
        check_eq("o_tlast", 64'(out_if.tlast), 64'd1);
        got_data.push_back(out_if.tdata);
        got_vis.push_back(cur_vis);
      end
    end
    prev_v   = out_if.tvalid;
    prev_pop = out_if.tvalid && out_if.tready;
    cyc++;
  end

  task automatic drive_ready();
    stall_active = 1'b0;
    if (stall_left > 0) begin
      out_if.tready = 1'b0;
      stall_left--;
      stall_active = 1'b1;
    end else if (bp_arm && out_if.tvalid) begin
      bp_arm        = 1'b0;
      stall_left    = 4;
      out_if.tready = 1'b0;
      stall_active  = 1'b1;
    end else if (rnd_ready) begin
      out_if.tready = ($urandom_range(0, 3) != 0);
    end else begin
      out_if.tready = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_ready();
  endtask

  task automatic send(input logic [31:0] d);
    bit acc;
    if (rnd_gap) begin
      while ($urandom_range(0, 3) == 0) begin
        in_if.tvalid = 1'b0;
        tick();
      end
    end
    in_if.tdata  = d;
    in_if.tvalid = 1'b1;
    in_if.tlast  = 1'($urandom_range(0, 1));
    acc = 1'b0;
    for (int n = 0; n < 1000 && !acc; n++) begin
      @(negedge clk);
      acc = in_if.tready;
      tick();
    end
    if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
    in_if.tvalid = 1'b0;
  endtask

  task automatic send_win(input int unsigned len, input int unsigned base,
                          input logic [31:0] vals [8]);
    for (int unsigned i = 0; i < len; i++) begin
      send((i >= base && i - base < 8) ? vals[i - base] : 32'd0);
    end
  endtask

  task automatic seg_start(input logic [31:0] thr);
    seg_data.delete();
    seg_cyc.delete();
    got_data.delete();
    got_vis.delete();
    threshold = thr;
  endtask

  // Reference: scan the accepted stream for crossings, take the earliest maximum of each
  // complete window, then skip the window plus any holdoff.
  task automatic model_check(input string tag);
    logic [63:0] exp_d[$];
    int unsigned exp_v[$];
    int unsigned i = 0;
    int unsigned n = seg_data.size();
    int unsigned pk;
    while (i < n) begin
      if (seg_data[i] > threshold) begin
        if (i + Half > n) break;
        pk = i;
        for (int unsigned k = i + 1; k < i + Half; k++) begin
          if (seg_data[k] > seg_data[pk]) pk = k;
        end
        exp_d.push_back({32'(pk), seg_data[pk]});
        exp_v.push_back(seg_cyc[i + Half - 1] + 1);
        i = i + Half + Holdoff;
      end else begin
        i++;
      end
    end
    check_eq({tag, "_count"}, 64'(got_data.size()), 64'(exp_d.size()));
    for (int k = 0; k < exp_d.size() && k < got_data.size(); k++) begin
      check_eq({tag, "_result"}, got_data[k], exp_d[k]);
      check_eq({tag, "_latency"}, 64'(got_vis[k]), 64'(exp_v[k]));
    end
  endtask

  task automatic end_segment(input bit flush, input string tag);
    in_if.tvalid = 1'b0;
    if (flush) begin
      rnd_ready = 1'b0;
      repeat (4) tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_check(tag);
  endtask

  function automatic logic [63:0] got_at(input int k);
    return (k < got_data.size()) ? got_data[k] : '1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] thr;
    logic [31:0] v;
    int          burst;
    reset         = 1'b1;
    clear         = 1'b0;
    threshold     = 32'd100;
    in_if.tvalid  = 1'b0;
    in_if.tdata   = 32'd0;
    in_if.tlast   = 1'b0;
    out_if.tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_o_tvalid", 64'(out_if.tvalid), 64'd0);
    check_eq("rst_o_tdata", out_if.tdata, 64'd0);
    check_eq("rst_o_tlast", 64'(out_if.tlast), 64'd0);
    check_eq("rst_i_tready", 64'(in_if.tready), 64'd1);
    tick();

    // No crossing: constant metric below threshold.
    seg_start(32'd100);
    chk_ready_hi = 1'b1;
    repeat (64) send(32'd50);
    chk_ready_hi = 1'b0;
    end_segment(1'b1, "s1");

    // Single burst.
    seg_start(32'd100);
    send_win(40, 10, s2);
    end_segment(1'b1, "s2");
    check_eq("s2_directed", got_at(0), 64'h0000000C_000001F4);

    // Tie keeps earliest; metric equal to threshold does not trigger.
    seg_start(32'd100);
    send_win(24, 10, s3);
    send(32'd100);
    repeat (12) send(32'd0);
    end_segment(1'b1, "s3");
    check_eq("s3_tie", got_at(0), 64'h0000000B_000001F4);

    // Back-pressure for five cycles, then a second burst at index 40.
    seg_start(32'd100);
    bp_arm = 1'b1;
    send_win(20, 10, s2);
    send_win(40, 20, s2);
    end_segment(1'b1, "s4");
    check_eq("s4_second", got_at(1), 64'h0000002A_000001F4);

    // Second burst at 20 lands inside the holdoff when it is compiled in.
    seg_start(32'd100);
    for (int unsigned i = 0; i < 50; i++) begin
      if (i >= 10 && i < 18)      v = s2[i - 10];
      else if (i >= 20 && i < 28) v = 32'd300;
      else if (i >= 34 && i < 42) v = (i == 35) ? 32'd600 : 32'd400;
      else                        v = 32'd0;
      send(v);
    end
    end_segment(1'b1, "s5");
`ifdef SC_PEAK_HOLDOFF_EN
    check_eq("s5_holdoff", got_at(1), 64'h00000023_00000258);
`else
    check_eq("s5_retrigger", got_at(1), 64'h00000014_0000012C);
`endif

    // Clear mid-search drops the window; indices restart at 0 afterwards.
    seg_start(32'd100);
    send_win(14, 10, s2);
    end_segment(1'b0, "s6_abort");
    seg_start(32'd100);
    send_win(24, 5, s2);
    end_segment(1'b1, "s6_restart");
    check_eq("s6_index", got_at(0), 64'h00000007_000001F4);

    // Random streams with gaps, random output back-pressure and bursts around threshold.
    for (int seg = 0; seg < 8; seg++) begin
      thr = (seg == 7) ? 32'hFFFF_FFFF : 32'($urandom_range(100, 100000));
      seg_start(thr);
      rnd_ready = 1'b1;
      rnd_gap   = 1'b1;
      burst     = 0;
      for (int i = 0; i < 120; i++) begin
        if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(1, 10);
        if (seg == 7) begin
          v = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom();
        end else if (burst > 0) begin
          v = thr + 32'($urandom_range(0, 3000));
          if ($urandom_range(0, 5) == 0) v = thr;
          burst--;
        end else begin
          v = 32'($urandom_range(0, thr));
        end
        send(v);
      end
      rnd_gap = 1'b0;
      end_segment(1'b1, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/schmidl_cox_peak_detector.md
# schmidl_cox_peak_detector

Consumes the Schmidl-Cox timing metric M(d) stream (32-bit unsigned quotient from the metric calculator) and finds the frame start. A threshold crossing opens a fixed search window of FFT_SIZE/2 samples. The block reports the index and value of the largest metric inside that window as a single-beat result packet. It sits directly downstream of the metric calculator and feeds the frame-alignment and CFO stages.

## Interface

Parameters:
- FFT_SIZE, 1024: OFDM symbol length. Power of two, ≥ 4. HALF_FFT_SIZE = FFT_SIZE/2 is the search window length.

Ports:
- clk  in  1  block clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous, active-high soft reset with the same effect as reset
- threshold  in  32  unsigned detection threshold; quasi-static, read combinationally every cycle
- i_tdata  in  32  unsigned metric M(d)
- i_tlast  in  1  ignored
- i_tvalid  in  1  metric valid
- i_tready  out  1  metric ready
- o_tdata  out  64  result: {peak_index[63:32], peak_metric[31:0]}
- o_tlast  out  1  always 1 while o_tvalid is high (single-beat packets)
- o_tvalid  out  1  result valid
- o_tready  in  1  result ready

## Operation

- Sample counter `cnt` (32 bits):
  - Holds the index of the next accepted sample; the first sample after reset or clear has index 0.
  - Increments on every accepted beat (i_tvalid && i_tready) in every state.
  - Wraps from 0xFFFFFFFF to 0.
- Comparisons are unsigned. A sample qualifies only if it is strictly greater than threshold. threshold = 0xFFFFFFFF never triggers.
- FSM states: IDLE, SEARCH, HOLDOFF (HOLDOFF exists only with the macro defined).
  - IDLE: on an accepted sample with metric > threshold, load peak_val = metric, peak_idx = cnt, win_cnt = 1, and go to SEARCH. Otherwise stay in IDLE.
  - SEARCH: on each accepted sample, increment win_cnt. If metric > peak_val (strict), update peak_val and peak_idx, so on ties the earliest peak is kept. Samples below threshold still belong to the window.
    - When the accepted sample makes win_cnt == HALF_FFT_SIZE, load the output register with {peak_idx, peak_val}, with that sample included in the comparison.
    - Then go to HOLDOFF (macro defined) or IDLE.
  - HOLDOFF: count FFT_SIZE accepted samples, starting with the first sample after the window. The sample that completes the count returns the FSM to IDLE. Samples accepted in HOLDOFF are never compared.
- Input tlast has no effect on the counter or the FSM.
- reset or clear:
  - FSM goes to IDLE; cnt, win_cnt, peak_val and peak_idx go to 0.
  - o_tvalid goes to 0. Any pending result is dropped.
  - Reset or clear mid-SEARCH produces no result.

## Timing

- Reset values: o_tvalid = 0, o_tdata = 0, o_tlast = 0, i_tready = 1.
- i_tready = !o_tvalid || o_tready (combinational). The input stalls only while a result is pending and not being taken.
- Result latency: o_tvalid rises on the cycle after the beat that closes the window. o_tlast = 1 in the same cycle.
- o_tvalid and o_tdata hold stable until o_tvalid && o_tready.
- When a result is accepted in the same cycle that another window closes, the new result loads and o_tvalid stays high. No result is lost or duplicated.
- Throughput: one metric per cycle when there is no back-pressure.
- Zero-bubble: the FSM uses the registered state only. No combinational path exists from i_tdata to o_*.

## Configuration

- SC_PEAK_HOLDOFF_EN:
  - Defined: the HOLDOFF state is compiled in. After each detection, the next FFT_SIZE accepted samples are ignored, which suppresses re-triggering on the metric plateau.
  - Not defined: the FSM returns from SEARCH directly to IDLE. A qualifying sample immediately after the window opens a new search.

## Test plan

All scenarios use FFT_SIZE = 16, so the window is 8 samples.

1. threshold = 100, 64 samples all equal to 50 → no o_tvalid; i_tready stays 1 throughout.
2. Indices 10..17 carry 200, 300, 500, 400, 350, 300, 280, 250; all other samples 0; threshold = 100 → exactly one result {0x0000000C, 0x000001F4}, with o_tvalid rising the cycle after index 17 is accepted and o_tlast = 1.
3. Tie: window 10..17 with 500 at both index 11 and index 14, everything else lower → peak_index = 11. Separately, a sample equal to threshold (100) alone → no trigger.
4. Scenario 2 with o_tready held low for 5 cycles after o_tvalid → i_tready low for those 5 cycles and o_tdata stable; afterwards the stream resumes with no lost samples, and the next detection reports a correctly counted index.
5. Holdoff: a window at 10..17, then a second burst > threshold starting at index 20:
   - With SC_PEAK_HOLDOFF_EN: the burst at 20 is ignored (holdoff covers 18..33), and a burst at 34 yields peak_index ≥ 34.
   - Without the macro: the burst at 20 is detected.
6. Assert clear for 1 cycle mid-SEARCH (after index 13) → no result. The next accepted sample has index 0, and a subsequent threshold crossing reports indices counted from that restart.
